// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that shares one ALU between NREQ requesters. One
//   operation is in flight at a time: IDLE accepts a request, WAIT covers the
//   ALU latency, and RESP returns the captured result to the granted requester.
//
//   Handshake rule for both request and response channels: a transfer happens
//   on a rising clk edge where valid and ready of the same index are both 1.
//   valid never depends combinationally on ready on the producer side.
//   req_ready is combinational in IDLE. rsp_valid is registered.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   req_valid/req_ready      per-requester request handshake (ready one-hot)
//   req_a/req_b/req_sel      packed operands, requester i at [i*W +: W]
//   alu_a/alu_b/alu_sel      registered operands driven to the ALU
//   alu_result               ALU output, sampled on the last WAIT edge
//   rsp_valid/rsp_ready      per-requester response handshake (valid one-hot)
//   rsp_data                 captured result, held after the response
//   busy                     high whenever the FSM is not in IDLE
//   state_dbg                current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int SW      = 2,
  parameter int RW      = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*SW-1:0]   req_sel,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [SW-1:0]        alu_sel,
  input  logic [RW-1:0]        alu_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [RW-1:0]        rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int PW = $clog2(NREQ);
  // Counter must hold ALU_LAT; +2 keeps it at least one bit wide when ALU_LAT=0.
  localparam int CW = $clog2(ALU_LAT + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [SW-1:0]   alu_sel_q, alu_sel_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;

  // Round-robin scan starting at rr_ptr; the first valid index wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        // The winner is valid by construction, so ready alone completes
        // the handshake on this edge.
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          alu_a_d   = req_a[win_idx*DW +: DW];
          alu_b_d   = req_b[win_idx*DW +: DW];
          alu_sel_d = req_sel[win_idx*SW +: SW];
          grant_d   = win_idx;
          cnt_d     = CW'(ALU_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d           = alu_result;
          rsp_valid_d          = '0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // Only the granted index's rsp_ready matters.
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
          // Granted requester drops to lowest priority next round.
          rr_ptr_d    = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: registered ALU, ALU_LAT=1 ----------------
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic [7:0]  req_sel = '0;
  logic [3:0]  alu_a, alu_b;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_result;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_ready = 4'hF;
  logic        busy;
  logic [1:0]  state_dbg;

  alu_arbiter #(.NREQ(4), .DW(4), .SW(2), .RW(8), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .state_dbg(state_dbg)
  );

  always @(posedge clk) alu_result <= {alu_sel, 6'b0} + {4'b0, alu_a} + {4'b0, alu_b};

  // ---------------- DUT B: combinational ALU, ALU_LAT=0 ----------------
  logic [3:0]  b_req_valid = '0;
  logic [3:0]  b_req_ready;
  logic [15:0] b_req_a = '0, b_req_b = '0;
  logic [7:0]  b_req_sel = '0;
  logic [3:0]  b_alu_a, b_alu_b;
  logic [1:0]  b_alu_sel;
  logic [7:0]  b_alu_result;
  logic [3:0]  b_rsp_valid;
  logic [7:0]  b_rsp_data;
  logic [3:0]  b_rsp_ready = 4'hF;
  logic        b_busy;
  logic [1:0]  b_state_dbg;

  alu_arbiter #(.NREQ(4), .DW(4), .SW(2), .RW(8), .ALU_LAT(0)) u_dut_comb (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .req_sel(b_req_sel),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_sel(b_alu_sel),
    .alu_result(b_alu_result),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_ready(b_rsp_ready),
    .busy(b_busy), .state_dbg(b_state_dbg)
  );

  assign b_alu_result = {b_alu_sel, 6'b0} + {4'b0, b_alu_a} + {4'b0, b_alu_b};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_model(input logic [9:0] op);
    // op = {sel, b, a}
    return {op[9:8], 6'b0} + {4'b0, op[7:4]} + {4'b0, op[3:0]};
  endfunction

  // ---------------- driver: per-requester operation queues ----------------
  logic [9:0] pend_q [4][$];
  logic [3:0] hs_pend = '0;

  task automatic push_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    pend_q[i].push_back({sel, b, a});
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs_pend[i] && pend_q[i].size() > 0) void'(pend_q[i].pop_front());
      if (pend_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        {req_sel[i*2 +: 2], req_b[i*4 +: 4], req_a[i*4 +: 4]} = pend_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    hs_pend = '0;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [9:0]  exp_q[$];   // {grant index, expected result}
  logic [15:0] gnt_hist = '0;
  int          gnt_cnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_pend[i] = 1'b1;
          gnt_hist   = {gnt_hist[13:0], 2'(i)};
          gnt_cnt++;
          exp_q.push_back({2'(i), alu_model(pend_q[i][0])});
        end
      end
      if ((rsp_valid & rsp_ready) != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("rsp_idx", 32'(rsp_valid), 32'(4'b0001 << e[9:8]));
          check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
        end
      end
    end
  end

  function automatic bit all_idle();
    bit r;
    r = (exp_q.size() == 0) && !busy;
    for (int i = 0; i < 4; i++) if (pend_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_drain(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (all_idle()) break;
    end
    check(tag, 32'(k < 300), 32'd1);
  endtask

  task automatic clear_hist();
    gnt_hist = '0;
    gnt_cnt  = 0;
  endtask

  task automatic flush_bench();
    for (int i = 0; i < 4; i++) pend_q[i].delete();
    exp_q.delete();
    hs_pend   = '0;
    req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_bench();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    do_reset();
    @(negedge clk);
    check("reset_outs", {rsp_valid, rsp_data, alu_a, alu_b, alu_sel, busy, req_ready},
          32'h0);
    check("reset_state", 32'(state_dbg), 32'd0);

    // Test 1: single op on requester 0, exact cycle timing.
    clear_hist();
    push_op(0, 4'd3, 4'd1, 2'd0);
    @(posedge clk); #2;
    @(negedge clk);                                   // cycle 0
    check("t1_ready_c0", 32'(req_ready), 32'h1);
    check("t1_busy_c0", 32'(busy), 32'd0);
    @(negedge clk);                                   // cycle 1
    check("t1_alu_ops_c1", 32'({alu_a, alu_b, alu_sel}), 32'({4'd3, 4'd1, 2'd0}));
    check("t1_busy_c1", 32'({busy, req_ready}), 32'({1'b1, 4'b0}));
    check("t1_state_c1", 32'(state_dbg), 32'd1);
    @(negedge clk);                                   // cycle 2
    check("t1_rsp_c2", 32'(rsp_valid), 32'h0);
    @(negedge clk);                                   // cycle 3
    check("t1_rsp_c3", 32'({rsp_valid, rsp_data}), 32'({4'b0001, 8'h04}));
    check("t1_state_c3", 32'(state_dbg), 32'd2);
    wait_drain("t1_drain");
    check("t1_rsp_hold", 32'(rsp_data), 32'h04);

    // Test 2: all four valid after reset -> grants 0,1,2,3.
    do_reset();
    clear_hist();
    push_op(0, 4'd1,  4'd2,  2'd0);
    push_op(1, 4'd4,  4'd5,  2'd1);
    push_op(2, 4'd15, 4'd15, 2'd2);
    push_op(3, 4'd8,  4'd9,  2'd3);
    wait_drain("t2_drain");
    check("t2_gnt_cnt", 32'(gnt_cnt), 32'd4);
    check("t2_gnt_order", 32'(gnt_hist[7:0]), 32'h1B);      // 0,1,2,3

    // Test 3: fairness, req0 and req2 held valid for six ops.
    clear_hist();
    push_op(0, 4'd1, 4'd1, 2'd0);
    push_op(0, 4'd2, 4'd2, 2'd1);
    push_op(0, 4'd3, 4'd3, 2'd2);
    push_op(2, 4'd4, 4'd4, 2'd3);
    push_op(2, 4'd5, 4'd5, 2'd0);
    push_op(2, 4'd6, 4'd6, 2'd1);
    wait_drain("t3_drain");
    check("t3_gnt_cnt", 32'(gnt_cnt), 32'd6);
    check("t3_gnt_order", 32'(gnt_hist[11:0]), 32'h222);    // 0,2,0,2,0,2

    // Test 4: response backpressure for 5 cycles, competing request pending.
    clear_hist();
    rsp_ready = 4'h0;
    push_op(1, 4'd7, 4'd2, 2'd2);
    begin
      int k;
      for (k = 0; k < 20 && rsp_valid == 4'b0; k++) @(negedge clk);
      check("t4_reach_resp", 32'(rsp_valid != 4'b0), 32'd1);
    end
    push_op(2, 4'd9, 4'd1, 2'd0);
    for (int c = 0; c < 5; c++) begin
      check("t4_bp_hold", 32'({rsp_valid, rsp_data, req_ready, busy}),
            32'({4'b0010, 8'h89, 4'b0000, 1'b1}));
      @(negedge clk);
    end
    check("t4_req2_waiting", 32'(req_valid[2]), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 4'hF;
    wait_drain("t4_drain");
    check("t4_gnt_order", 32'({gnt_cnt[3:0], gnt_hist[3:0]}), 32'h26);  // 1 then 2

    // Test 5: reset during WAIT discards the op and restarts rr at 0.
    clear_hist();
    push_op(2, 4'd1, 4'd1, 2'd0);
    begin
      int k;
      for (k = 0; k < 20 && !busy; k++) @(negedge clk);
      check("t5_reach_wait", 32'(state_dbg), 32'd1);
    end
    #2;
    rst = 1'b0;
    flush_bench();
    #1;
    check("t5_async_clear", {rsp_valid, rsp_data, alu_a, alu_b, alu_sel, busy, req_ready},
          32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_no_rsp_in_rst", 32'({rsp_valid, state_dbg}), 32'h0);
    rst = 1'b1;
    clear_hist();
    push_op(1, 4'd2, 4'd2, 2'd0);
    push_op(3, 4'd3, 4'd3, 2'd1);
    wait_drain("t5_drain");
    check("t5_gnt_order", 32'({gnt_cnt[3:0], gnt_hist[3:0]}), 32'h27);  // 1 then 3

    // Test 6: ALU_LAT=0 instance, requester 1, a=5 b=6 sel=1 -> 8'h4B.
    @(posedge clk); #1;
    b_req_valid        = 4'b0010;
    b_req_a[4 +: 4]    = 4'd5;
    b_req_b[4 +: 4]    = 4'd6;
    b_req_sel[2 +: 2]  = 2'd1;
    @(negedge clk);                                   // cycle 0
    check("t6_ready_c0", 32'(b_req_ready), 32'h2);
    @(posedge clk); #1;
    b_req_valid = 4'b0;
    @(negedge clk);                                   // cycle 1
    check("t6_alu_ops_c1", 32'({b_alu_a, b_alu_b, b_alu_sel}), 32'({4'd5, 4'd6, 2'd1}));
    check("t6_rsp_c1", 32'(b_rsp_valid), 32'h0);
    @(negedge clk);                                   // cycle 2
    check("t6_rsp_c2", 32'({b_rsp_valid, b_rsp_data}), 32'({4'b0010, 8'h4B}));
    @(negedge clk);                                   // cycle 3, response taken
    check("t6_done_c3", 32'({b_rsp_valid, b_busy, b_rsp_data}), 32'({4'b0, 1'b0, 8'h4B}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
